// File: rtl/pikachu_hit_reaction.sv
// Defender hit reaction: recoil right and back, blink, then drain HP one point per frame.
// Every output is registered; the next-state logic is computed combinationally and registered in one place.
module pikachu_hit_reaction #(
  parameter int RECOIL_PX    = 8,
  parameter int BLINK_FRAMES = 6,
  parameter int HP_MAX       = 100
) (
  input  logic       clock,
  input  logic       reset_all,
  input  logic       frame_tick,
  input  logic       hit_strobe,
  input  logic [7:0] damage,
  output logic [8:0] offset_x,
  output logic       visible,
  output logic [7:0] hp,
  output logic       busy,
  output logic       done_hit,
  output logic       fainted
);

  localparam logic [8:0] LP_PEAK  = 9'(RECOIL_PX);
  localparam logic [7:0] LP_BLINK = 8'(BLINK_FRAMES);
  localparam logic [7:0] LP_HP    = 8'(HP_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECOIL_OUT,
    S_RECOIL_BACK,
    S_BLINK,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t     r_state, w_state_nx;
  logic [8:0] r_offset, w_offset_nx;
  logic       r_visible, w_visible_nx;
  logic [7:0] r_hp, w_hp_nx;
  logic       r_busy, w_busy_nx;
  logic       r_done, w_done_nx;
  logic       r_fainted, w_fainted_nx;
  logic [7:0] r_pending, w_pending_nx;
  logic [7:0] r_blink_cnt, w_blink_cnt_nx;

  // Decrement that holds at zero, so neither HP nor the pending damage can wrap.
  function automatic logic [7:0] sat_dec8(input logic [7:0] v);
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

  always_ff @(posedge clock or posedge reset_all) begin
    if (reset_all) begin
      r_state     <= S_IDLE;
      r_offset    <= 9'd0;
      r_visible   <= 1'b1;
      r_hp        <= LP_HP;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fainted   <= 1'b0;
      r_pending   <= 8'd0;
      r_blink_cnt <= 8'd0;
    end else begin
      r_state     <= w_state_nx;
      r_offset    <= w_offset_nx;
      r_visible   <= w_visible_nx;
      r_hp        <= w_hp_nx;
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
      r_fainted   <= w_fainted_nx;
      r_pending   <= w_pending_nx;
      r_blink_cnt <= w_blink_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_offset_nx    = r_offset;
    w_visible_nx   = r_visible;
    w_hp_nx        = r_hp;
    w_busy_nx      = r_busy;
    w_done_nx      = 1'b0;
    w_fainted_nx   = r_fainted;
    w_pending_nx   = r_pending;
    w_blink_cnt_nx = r_blink_cnt;

    case (r_state)
      // A frame_tick coinciding with the accepted hit is deliberately not used for motion.
      S_IDLE: begin
        if (hit_strobe && !r_fainted) begin
          w_pending_nx = damage;
          w_busy_nx    = 1'b1;
          w_state_nx   = S_RECOIL_OUT;
        end
      end
      S_RECOIL_OUT: begin
        if (frame_tick) begin
          w_offset_nx = r_offset + 9'd1;
          if ((r_offset + 9'd1) == LP_PEAK) w_state_nx = S_RECOIL_BACK;
        end
      end
      S_RECOIL_BACK: begin
        if (frame_tick) begin
          w_offset_nx = r_offset - 9'd1;
          if ((r_offset - 9'd1) == 9'd0) begin
            w_blink_cnt_nx = 8'd0;
            w_state_nx     = S_BLINK;
          end
        end
      end
      S_BLINK: begin
        if (frame_tick) begin
          w_visible_nx   = ~r_visible;
          w_blink_cnt_nx = r_blink_cnt + 8'd1;
          if ((r_blink_cnt + 8'd1) == LP_BLINK) w_state_nx = S_DRAIN;
        end
      end
      // Exit does not wait for a tick; leftover pending damage is dropped once HP is empty.
      S_DRAIN: begin
        if ((r_pending == 8'd0) || (r_hp == 8'd0)) begin
          w_state_nx = S_DONE;
          w_done_nx  = 1'b1;
          if (r_hp == 8'd0) w_fainted_nx = 1'b1;
        end else if (frame_tick) begin
          w_hp_nx      = sat_dec8(r_hp);
          w_pending_nx = sat_dec8(r_pending);
        end
      end
      S_DONE: begin
        w_busy_nx  = 1'b0;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign offset_x = r_offset;
  assign visible  = r_visible;
  assign hp       = r_hp;
  assign busy     = r_busy;
  assign done_hit = r_done;
  assign fainted  = r_fainted;

endmodule

// File: tb/tb_pikachu_hit_reaction.sv
// Scoreboard bench for pikachu_hit_reaction: the driver queues hand-computed results per hit,
// a negedge monitor tracks motion/blink/tick counts and compares them on every done_hit.
module tb_pikachu_hit_reaction;

  logic       clock = 1'b0;
  logic       reset_all;
  logic       frame_tick;
  logic       hit_strobe;
  logic [7:0] damage;
  logic [8:0] offset_x;
  logic       visible;
  logic [7:0] hp;
  logic       busy;
  logic       done_hit;
  logic       fainted;

  pikachu_hit_reaction #(
    .RECOIL_PX   (8),
    .BLINK_FRAMES(6),
    .HP_MAX      (100)
  ) dut (
    .clock     (clock),
    .reset_all (reset_all),
    .frame_tick(frame_tick),
    .hit_strobe(hit_strobe),
    .damage    (damage),
    .offset_x  (offset_x),
    .visible   (visible),
    .hp        (hp),
    .busy      (busy),
    .done_hit  (done_hit),
    .fainted   (fainted)
  );

  always #5 clock = ~clock;

  typedef struct {
    int hp;
    int fnt;
    int ticks;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: observes once per cycle at the falling edge.
  int   m_ticks = 0;
  int   m_since = 0;
  int   m_peak = 0;
  int   m_toggles = 0;
  logic m_prev_vis = 1'b1;

  always @(negedge clock) begin
    if (reset_all) begin
      q.delete();
      m_ticks = 0; m_since = 0; m_peak = 0; m_toggles = 0;
      m_prev_vis = 1'b1;
    end else begin
      if (busy) begin
        if (frame_tick && !done_hit) begin
          m_ticks++;
          m_since = 0;
        end else begin
          m_since++;
        end
        if (int'(offset_x) > m_peak) m_peak = int'(offset_x);
        if (visible != m_prev_vis) m_toggles++;
      end
      m_prev_vis = visible;
      if (done_hit) begin
        if (q.size() == 0) begin
          chk("unexpected_done_hit", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_hp", int'(hp), e.hp);
          chk("done_fainted", int'(fainted), e.fnt);
          chk("done_ticks", m_ticks, e.ticks);
          chk("done_latency_clk", m_since, 2);
          chk("peak_offset", m_peak, 8);
          chk("blink_toggles", m_toggles, 6);
          chk("done_offset", int'(offset_x), 0);
          chk("done_visible", int'(visible), 1);
        end
        m_ticks = 0; m_since = 0; m_peak = 0; m_toggles = 0;
      end
    end
  end

  task automatic push(input int ehp, input int efnt, input int eticks);
    exp_t e;
    e.hp = ehp; e.fnt = efnt; e.ticks = eticks;
    q.push_back(e);
  endtask

  task automatic step(input logic t, input logic h, input logic [7:0] d);
    frame_tick = t; hit_strobe = h; damage = d;
    @(posedge clock); #1;
    frame_tick = 1'b0; hit_strobe = 1'b0; damage = 8'd0;
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) step((c % 4) == 3, 1'b0, 8'd0);
  endtask

  task automatic run_reaction(input int extra_at, input logic [7:0] extra_d);
    bit finished = 0;
    for (int c = 0; c < 4000; c++) begin
      step((c % 4) == 3, c == extra_at, (c == extra_at) ? extra_d : 8'd0);
      if (!busy) begin
        finished = 1;
        break;
      end
    end
    if (!finished) chk("reaction_timeout", 0, 1);
  endtask

  initial begin
    reset_all = 1'b1; frame_tick = 1'b0; hit_strobe = 1'b0; damage = 8'd0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_offset", int'(offset_x), 0);
    chk("rst_visible", int'(visible), 1);
    chk("rst_hp", int'(hp), 100);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done_hit), 0);
    chk("rst_fainted", int'(fainted), 0);
    reset_all = 1'b0;
    @(posedge clock); #1;

    // Damage 3 with a second hit (damage 50) arriving during RECOIL_OUT that must be ignored.
    push(97, 0, 25);
    step(1'b0, 1'b1, 8'd3);
    chk("accept_busy", int'(busy), 1);
    run_reaction(10, 8'd50);

    // Damage 0: full animation, HP unchanged.
    push(97, 0, 22);
    step(1'b0, 1'b1, 8'd0);
    run_reaction(-1, 8'd0);

    // Hit and tick in the same IDLE cycle: tick is not used for motion.
    push(96, 0, 23);
    step(1'b1, 1'b1, 8'd1);
    chk("same_cycle_busy", int'(busy), 1);
    chk("same_cycle_offset0", int'(offset_x), 0);
    run_cycles(4);
    chk("next_tick_offset1", int'(offset_x), 1);
    run_reaction(-1, 8'd0);

    // Reset asserted between edges in the middle of BLINK.
    step(1'b0, 1'b1, 8'd5);
    run_cycles(68);
    chk("midblink_visible", int'(visible), 0);
    chk("midblink_busy", int'(busy), 1);
    #2 reset_all = 1'b1;
    #1;
    chk("async_rst_offset", int'(offset_x), 0);
    chk("async_rst_visible", int'(visible), 1);
    chk("async_rst_hp", int'(hp), 100);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_fainted", int'(fainted), 0);
    @(posedge clock); #1;
    reset_all = 1'b0;
    @(posedge clock); #1;

    // Drain to 2, then overkill to 0 and faint.
    push(2, 0, 120);
    step(1'b0, 1'b1, 8'd98);
    run_reaction(-1, 8'd0);
    push(0, 1, 24);
    step(1'b0, 1'b1, 8'd10);
    run_reaction(-1, 8'd0);

    // Hit while fainted is ignored.
    step(1'b0, 1'b1, 8'd5);
    chk("fainted_hit_busy", int'(busy), 0);
    run_cycles(8);
    chk("fainted_offset", int'(offset_x), 0);
    chk("fainted_busy", int'(busy), 0);
    chk("fainted_hp", int'(hp), 0);
    chk("fainted_sticky", int'(fainted), 1);
    run_cycles(4);
    chk("scoreboard_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
